// File: rtl/bit_serializer_pkg.sv
// Shared types for the bit serializer front end.
// State encodings and the default word width.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/bit_serializer_hold.sv
// One-entry holding register in front of the shift register.
// Lets the producer hand over the next word while the current one shifts.
module bit_serializer_hold
    import bit_serializer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] hold_data,
    output logic              hold_full,
    output logic              in_ready
);

    logic [DATA_W-1:0] hold_d, hold_q;
    logic              full_d, full_q;

    // load only happens while empty, drain only while full
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (load) begin
            hold_d = din;
            full_d = 1'b1;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

    assign hold_data = hold_q;
    assign hold_full = full_q;
    assign in_ready  = !full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: words in over valid/ready,
// one bit per clock out on sout with a frame mark on the first bit.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sout,
    output logic              sout_valid,
    input  logic              sout_ready,
    output logic              sout_first,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);

    state_e            state_d, state_q;
    logic [DATA_W-1:0] shreg_d, shreg_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] shifted;
    logic              hold_full;
    logic              hold_load;
    logic              hold_drain;
    logic              xfer;
    logic              move;
    logic              last;

    bit_serializer_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load),
        .drain     (hold_drain),
        .din       (in_data),
        .hold_data (hold_data),
        .hold_full (hold_full),
        .in_ready  (in_ready)
    );

    assign xfer = in_valid & in_ready;
    assign move = (state_q == SHIFT) & sout_ready;
    assign last = (cnt_q == CNT_W'(DATA_W - 1));

    // vacated positions fill with zero
    assign shifted = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0}
                               : {1'b0, shreg_q[DATA_W-1:1]};

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        hold_load  = 1'b0;
        hold_drain = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (move && !last) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (move && hold_full) begin
                    shreg_d    = hold_data;
                    hold_drain = 1'b1;
                    cnt_d      = '0;
                end else if (move && xfer) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                end else if (move) begin
                    shreg_d = shifted;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                // a word arriving off the bypass path parks in the hold register
                hold_load = xfer && !(move && last);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sout       = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
    assign sout_valid = (state_q == SHIFT);
    assign sout_first = sout_valid & (cnt_q == '0);
    assign busy       = (state_q == SHIFT) | hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: 8-bit MSB-first instance
// plus a 4-bit LSB-first instance feeding a registered bit consumer.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sout;
    logic       sout_valid;
    logic       sout_ready;
    logic       sout_first;
    logic       busy;

    logic [3:0] in4_data;
    logic       in4_valid;
    logic       in4_ready;
    logic       sout4;
    logic       sout4_valid;
    logic       s4_ready;
    logic       sout4_first;
    logic       busy4;

    logic       cons_out = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .sout_first (sout_first),
        .busy       (busy)
    );

    bit_serializer #(.DATA_W(4), .MSB_FIRST(1'b0)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in4_data),
        .in_valid   (in4_valid),
        .in_ready   (in4_ready),
        .sout       (sout4),
        .sout_valid (sout4_valid),
        .sout_ready (s4_ready),
        .sout_first (sout4_first),
        .busy       (busy4)
    );

    // single-bit serial consumer: registers each moved bit
    always @(posedge clk)
        cons_out <= sout4_valid & s4_ready & sout4;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  prod_q[$];
    logic [31:0] c_bits;
    logic [31:0] c_first;
    int          c_vc;
    int          c_gaps;
    int          c_moved;
    logic        c_stall_ir;
    logic        c_saw_full;

    task automatic collect(input string tag, input int nbits,
                           input int stall_at, input int stall_len);
        int   cyc        = 0;
        int   stalled    = 0;
        logic started    = 1'b0;
        logic prev_stall = 1'b0;
        logic prev_sout  = 1'b0;
        logic prev_first = 1'b0;
        logic fire;
        c_bits = 0; c_first = 0; c_vc = 0; c_gaps = 0; c_moved = 0;
        c_stall_ir = 1'b1; c_saw_full = 1'b0;
        while (c_moved < nbits && cyc < 100) begin
            if (c_moved == stall_at && stalled < stall_len && sout_valid) begin
                sout_ready = 1'b0;
                stalled++;
            end else begin
                sout_ready = 1'b1;
            end
            in_valid = (prod_q.size() > 0);
            in_data  = in_valid ? prod_q[0] : 8'h00;
            if (prev_stall)
                chk({tag, "_frozen"}, {30'd0, sout, sout_first},
                    {30'd0, prev_sout, prev_first});
            if (sout_valid) begin
                c_vc++;
                started = 1'b1;
                if (!in_ready) c_saw_full = 1'b1;
            end else if (started) begin
                c_gaps++;
            end
            if (sout_valid && !sout_ready) c_stall_ir = c_stall_ir & in_ready;
            if (sout_valid && sout_ready) begin
                c_bits  = {c_bits[30:0], sout};
                c_first = {c_first[30:0], sout_first};
                c_moved++;
            end
            prev_stall = sout_valid && !sout_ready;
            prev_sout  = sout;
            prev_first = sout_first;
            fire = in_valid & in_ready;
            step;
            cyc++;
            if (fire) void'(prod_q.pop_front());
        end
        in_valid   = 1'b0;
        sout_ready = 1'b1;
        if (c_moved < nbits) chk({tag, "_timeout"}, c_moved, nbits);
        chk({tag, "_idle"}, {30'd0, sout_valid, busy}, 32'd0);
    endtask

    logic [3:0] exp4;
    int         vcnt;

    initial begin
        rst = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; sout_ready = 1'b1;
        in4_data = 4'h0; in4_valid = 1'b0; s4_ready = 1'b1;
        step;
        chk("rst_valid", sout_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_sout", sout, 1'b0);
        chk("rst_first", sout_first, 1'b0);
        rst = 1'b1;
        step;

        // reset mid-word at cnt=3
        in_valid = 1'b1; in_data = 8'hC3;
        step;
        in_valid = 1'b0;
        step; step; step;
        chk("t1_pre_valid", sout_valid, 1'b1);
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'hFF;
        step;
        chk("t1_valid", sout_valid, 1'b0);
        chk("t1_busy", busy, 1'b0);
        chk("t1_in_ready", in_ready, 1'b1);
        chk("t1_sout", sout, 1'b0);
        in_valid = 1'b0;
        step;
        rst = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (sout_valid || busy) vcnt++;
            step;
        end
        chk("t1_no_stale", vcnt, 0);

        // single word
        prod_q.push_back(8'hA5);
        collect("t2", 8, -1, 0);
        chk("t2_bits", c_bits, 32'hA5);
        chk("t2_first", c_first, 32'h80);
        chk("t2_vc", c_vc, 8);
        chk("t2_gaps", c_gaps, 0);

        // back-to-back words
        prod_q.push_back(8'hF0);
        prod_q.push_back(8'h0F);
        prod_q.push_back(8'h81);
        collect("t3", 24, -1, 0);
        chk("t3_bits", c_bits, 32'hF00F81);
        chk("t3_first", c_first, 32'h808080);
        chk("t3_vc", c_vc, 24);
        chk("t3_gaps", c_gaps, 0);
        chk("t3_full_seen", c_saw_full, 1'b1);

        // stall mid-word
        prod_q.push_back(8'h3C);
        collect("t4", 8, 4, 3);
        chk("t4_bits", c_bits, 32'h3C);
        chk("t4_first", c_first, 32'h80);
        chk("t4_vc", c_vc, 11);
        chk("t4_gaps", c_gaps, 0);

        // stall on last bit with hold full
        prod_q.push_back(8'hFF);
        prod_q.push_back(8'h00);
        collect("t5", 16, 7, 2);
        chk("t5_bits", c_bits, 32'hFF00);
        chk("t5_first", c_first, 32'h8080);
        chk("t5_vc", c_vc, 18);
        chk("t5_stall_in_ready", c_stall_ir, 1'b0);

        // LSB-first 4-bit instance
        exp4 = 4'b0011;
        in4_valid = 1'b1; in4_data = exp4;
        step;
        in4_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_valid%0d", i), sout4_valid, 1'b1);
            chk($sformatf("t6_sout%0d", i), sout4, exp4[i]);
            chk($sformatf("t6_first%0d", i), sout4_first, (i == 0));
            if (i > 0) chk($sformatf("t6_cons%0d", i), cons_out, exp4[i-1]);
            step;
        end
        chk("t6_cons_last", cons_out, exp4[3]);
        chk("t6_idle", {30'd0, sout4_valid, busy4}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
